reg_mem_fifo_ctrl: RTL
======================

Name: reg_mem_fifo_ctrl

Overview:
- Initiator-side controller that drives the write and read ports of a register-based memory brick and presents it as a ready/valid FIFO.
- The memory captures the read address on a clock edge and returns data combinationally from the registered address, so read data appears one cycle after the address is presented.
- The block hides this 1-cycle read latency with a 2-entry output buffer, sustaining 1 push and 1 pop per cycle.
- It sits between a stage producer and a consumer, wherever segment buffers or stage outputs are held in a memory brick.

Parameters:
- DATA_WIDTH, `LIM_BRICK_WORD_SIZE, word width.
- ADDR_WIDTH, `BITS_ADDR_LIM_BRICK, memory address width.
- DEPTH, `LIM_BRICK_WORD_NUM, memory words; must equal 2**ADDR_WIDTH.

Ports:
- CLK  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- in_valid  in  1  producer word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_WIDTH  producer word.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+2  total words held (memory plus output buffer).
- mem_wr_en  out  1  memory write enable.
- mem_wr_addr  out  ADDR_WIDTH  memory write address.
- WBL  out  DATA_WIDTH  memory write data.
- mem_rd_en  out  1  read issue strobe (informational; the memory registers the address every cycle).
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- ARBL  in  DATA_WIDTH  memory read data, valid the cycle after issue.

Behaviour:
- Reset (asynchronous, rst_b=0):
  - wr_ptr=0, rd_ptr=0, mem_used=0, inflight=0, ob_count=0.
  - Outputs: out_valid=0, mem_wr_en=0, mem_rd_en=0, count=0, in_ready=0 while in reset, 1 the first cycle after release.
  - Contents of out_data and the memory are don't-care.
- Push:
  - push = in_valid & in_ready, with in_ready = (mem_used < DEPTH), registered.
  - On push: mem_wr_en=1, mem_wr_addr=wr_ptr, WBL=in_data, all combinational from the inputs.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 to 0).
- Read issue:
  - issue = (mem_used - inflight > 0) & (ob_count + inflight - pop < 2).
  - On issue: mem_rd_en=1, mem_rd_addr=rd_ptr, rd_ptr increments modulo DEPTH; inflight sets for one cycle.
  - mem_rd_addr holds rd_ptr when not issuing.
- Capture:
  - The cycle after an issue, ARBL is written into the output buffer and mem_used decrements in that same cycle.
  - A slot therefore becomes writable only after its data is captured, so no write-before-read hazard exists on the registered address.
- Output buffer:
  - 2-entry, FIFO ordered. out_valid = (ob_count > 0); out_data = head entry (registered).
  - pop = out_valid & out_ready.
  - Simultaneous capture and pop keeps ob_count unchanged; the buffer never overflows by construction.
- Simultaneous events:
  - Push and capture in the same cycle: mem_used unchanged.
  - Push into an empty FIFO: first out_valid rises 3 cycles after the push cycle (write commit, then issue, then capture).
  - Full (mem_used=DEPTH): in_ready=0. Empty: out_valid=0 and no issue.
- Issue FSM:
  - IDLE: nothing inflight; go to FETCH on issue.
  - FETCH: inflight; go to FETCH on back-to-back issue, otherwise IDLE.
- count = mem_used + ob_count (a captured word moves from mem_used into ob_count in the same cycle, so it is not double-counted).
- Reset mid-operation: all state clears asynchronously and in-flight data is discarded. No memory clear is performed.

Optional Feature:
- Macro: REG_MEM_FIFO_HWM_EN.
- When defined:
  - Adds output hwm (ADDR_WIDTH+2 bits) and input hwm_clr (1 bit).
  - hwm is a registered maximum of count; resets to 0.
  - hwm_clr loads the current count.
- When undefined: neither port exists and there is no additional logic.

Decomposition:
- Package reg_mem_fifo_pkg holds:
  - the issue-state enum {IDLE, FETCH};
  - the function computing pointer width;
  - the constant OB_DEPTH=2.
- One natural sub-module: reg_mem_ob2, the 2-entry output buffer with push/pop/count.
- The memory brick is instantiated outside the block, alongside it.

Test Plan (bench: DATA_WIDTH=16, ADDR_WIDTH=3, DEPTH=8, controller connected to the memory brick):
- Single word: push 0xA5A5 into an empty FIFO with out_ready=1 -> out_valid rises 3 cycles later with out_data=0xA5A5; count goes 1 then 0.
- Fill: push 0x0000..0x0009 with out_ready=0 -> in_ready=0 when mem_used=8; count=10 (8 in memory, 2 in output buffer); then out_ready=1 drains 0x0000..0x0009 in order, one per cycle.
- Streaming: continuous push and pop of 100 words -> steady-state throughput 1 word/cycle, no gaps after the initial latency, order preserved, pointers wrap cleanly 7 to 0.
- Backpressure: toggle out_ready 1010... during streaming -> no loss or duplication; ob_count never exceeds 2.
- Reset mid-stream: assert rst_b=0 with count=5 -> out_valid=0 and count=0 immediately; after release, push 0x1234 -> output 0x1234 only.
- HWM (macro defined): push 6 words, pop all, pulse hwm_clr -> hwm=6 before the clear, 0 after.

Source files
------------

// File: rtl/reg_mem_fifo_ctrl_pkg.sv
// Shared types and constants for the register-memory FIFO controller.
package reg_mem_fifo_pkg;

  // Read-issue state: IDLE means no read in flight, FETCH means read data lands this cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } issue_state_e;

  // Output buffer depth that hides the one-cycle memory read latency.
  localparam int OB_DEPTH = 32'sd2;
  localparam int OB_CNT_W = $clog2(OB_DEPTH + 32'sd1);

  // Smallest pointer width able to address 'depth' words.
  function automatic int ptr_width(input int depth);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < depth) w = w + 32'sd1;
    return w;
  endfunction

endpackage

// File: rtl/reg_mem_fifo_ctrl_if.sv
// Producer/consumer ready-valid bundle of the register-memory FIFO.
// master: the side driving words in and accepting words out; slave: the controller.
interface reg_mem_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32'sd16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/reg_mem_fifo_ctrl_ob2.sv
// Two-entry output buffer: absorbs read data landing from the memory brick
// so the consumer sees a registered head word with no read-latency bubbles.
module reg_mem_ob2
  import reg_mem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32'sd16
) (
  input  logic                  CLK,
  input  logic                  rst_b,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OB_CNT_W-1:0]   count
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [OB_CNT_W-1:0]   count_r;

  // Head/tail shift register with occupancy; push+pop keeps occupancy constant.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == '0) head_r <= din;
          else               tail_r <= din;
          count_r <= count_r + OB_CNT_W'(1'b1);
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - OB_CNT_W'(1'b1);
        end
        2'b11: begin
          if (count_r == OB_CNT_W'(1'b1)) begin
            head_r <= din;
          end else begin
            head_r <= tail_r;
            tail_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign valid = (count_r != '0);
  assign dout  = head_r;
  assign count = count_r;

endmodule

// File: rtl/reg_mem_fifo_ctrl.sv
// Initiator-side controller presenting a register-based memory brick as a
// ready/valid FIFO. Memory reads return one cycle after the address is issued;
// a two-entry output buffer hides that latency for 1 push + 1 pop per cycle.
// Optional build macro: REG_MEM_FIFO_HWM_EN adds a count high-water mark
// (output hwm, input hwm_clr).
`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 16
`endif
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 3
`endif
`ifndef LIM_BRICK_WORD_NUM
`define LIM_BRICK_WORD_NUM 8
`endif

module reg_mem_fifo_ctrl
  import reg_mem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = `LIM_BRICK_WORD_SIZE,
  parameter int ADDR_WIDTH = `BITS_ADDR_LIM_BRICK,
  parameter int DEPTH      = `LIM_BRICK_WORD_NUM   // must be 2**ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  rst_b,
  reg_mem_fifo_ctrl_if.slave    bus,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] WBL,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] ARBL
`ifdef REG_MEM_FIFO_HWM_EN
  ,
  output logic [ADDR_WIDTH+1:0] hwm,
  input  logic                  hwm_clr
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int MU_W  = ADDR_WIDTH + 32'sd1;
  localparam int CNT_W = ADDR_WIDTH + 32'sd2;
  localparam int OBL_W = OB_CNT_W + 32'sd1;

  issue_state_e          state_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [MU_W-1:0]       mem_used_r;
  logic                  in_ready_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  issue_s;
  logic                  inflight_s;
  logic                  avail_s;
  logic                  room_s;
  logic [OBL_W-1:0]      ob_load_s;
  logic [MU_W-1:0]       mem_used_nxt_s;
  logic                  ob_valid_s;
  logic [DATA_WIDTH-1:0] ob_data_s;
  logic [OB_CNT_W-1:0]   ob_count_s;

  assign inflight_s = (state_r == FETCH);
  assign push_s     = bus.in_valid & in_ready_r;
  assign pop_s      = ob_valid_s & bus.out_ready;

  // Issue a read when memory holds an unfetched word and the buffer will have room when it lands.
  always_comb begin
    avail_s   = (mem_used_r > MU_W'(inflight_s));
    ob_load_s = OBL_W'(ob_count_s) + OBL_W'(inflight_s);
    room_s    = (ob_load_s < (OBL_W'(OB_DEPTH) + OBL_W'(pop_s)));
    issue_s   = avail_s & room_s;
  end

  // Memory occupancy: a write adds a word, a capture into the buffer removes one.
  always_comb begin
    mem_used_nxt_s = mem_used_r;
    if (push_s && !inflight_s) begin
      mem_used_nxt_s = mem_used_r + MU_W'(1'b1);
    end else if (inflight_s && !push_s) begin
      mem_used_nxt_s = mem_used_r - MU_W'(1'b1);
    end else begin
      mem_used_nxt_s = mem_used_r;
    end
  end

  // Pointers, occupancy and the registered accept flag.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      mem_used_r <= '0;
      in_ready_r <= 1'b0;
    end else begin
      if (push_s)  wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      else         wr_ptr_r <= wr_ptr_r;
      if (issue_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      else         rd_ptr_r <= rd_ptr_r;
      mem_used_r <= mem_used_nxt_s;
      in_ready_r <= (mem_used_nxt_s < MU_W'(DEPTH));
    end
  end

  // Issue FSM: FETCH marks the cycle in which read data from the previous issue is valid.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= issue_s ? FETCH : IDLE;
        FETCH:   state_r <= issue_s ? FETCH : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  reg_mem_ob2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ob (
    .CLK  (CLK),
    .rst_b(rst_b),
    .push (inflight_s),
    .din  (ARBL),
    .pop  (pop_s),
    .valid(ob_valid_s),
    .dout (ob_data_s),
    .count(ob_count_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = ob_valid_s;
  assign bus.out_data  = ob_data_s;
  assign mem_wr_en     = push_s;
  assign mem_wr_addr   = ADDR_WIDTH'(wr_ptr_r);
  assign WBL           = bus.in_data;
  assign mem_rd_en     = issue_s;
  assign mem_rd_addr   = ADDR_WIDTH'(rd_ptr_r);
  // A captured word leaves mem_used the same cycle it enters the buffer, so no double count.
  assign count         = CNT_W'(mem_used_r) + CNT_W'(ob_count_s);

`ifdef REG_MEM_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_r;

  // High-water mark of total occupancy; a clear reloads it with the present count.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      hwm_r <= '0;
    end else if (hwm_clr) begin
      hwm_r <= count;
    end else if (count > hwm_r) begin
      hwm_r <= count;
    end else begin
      hwm_r <= hwm_r;
    end
  end

  assign hwm = hwm_r;
`endif

endmodule
